pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage cpu_pipelined core (IF/ID/EX/MEM/WB).
//  Detects load-use hazards, selects EX operand forwarding, and flushes on a branch taken in EX.
//  Detects the all-zero end-of-program word in ID, drains the pipeline, then raises end_program.
//  Keeps saturating cycle, stall and flush counters for the bench's execution-time reports.
// PARAMETERS
//  DRAIN_CYCLES  4   cycles spent in DRAIN after halt is accepted, so the last real instr retires
//  CNT_W         32  width of cycle_count; stall_count and flush_count are 16 bits, fixed
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous active-low reset (asserted when 0)
//  id_rs1,id_rs2  in   5      source regs of the instruction in IF/ID
//  id_use_rs1/2   in   1      ID instruction actually reads rs1/rs2
//  id_halt        in   1      IF/ID instruction word == 32'h0
//  ex_rs1,ex_rs2  in   5      source regs in ID/EX (forwarding compare)
//  ex_rd          in   5      dest reg in ID/EX
//  ex_mem_read    in   1      ID/EX instruction is a load
//  ex_branch_taken in  1      beq in EX resolved taken
//  mem_rd         in   5      dest reg in EX/MEM
//  mem_reg_write  in   1      EX/MEM writes a register
//  wb_rd          in   5      dest reg in MEM/WB
//  wb_reg_write   in   1      MEM/WB writes a register
//  pc_write       out  1      PC update enable
//  if_id_write    out  1      IF/ID latch enable
//  if_id_flush    out  1      IF/ID -> NOP on next edge
//  id_ex_bubble   out  1      ID/EX control -> zero on next edge
//  fwd_a,fwd_b    out  2      00 regfile, 10 EX/MEM result, 01 MEM/WB result
//  end_program    out  1      sticky; high once drain completes
//  cycle_count    out  CNT_W  cycles since reset release, frozen in DONE
//  stall_count    out  16     load-use stall cycles, saturating at 16'hFFFF
//  flush_count    out  16     branch flushes, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=RUN, counters=0, end_program=0. Comb outputs while reset low:
//   pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, fwd=00. Mid-run reset aborts everything.
//  Forwarding (comb, every state): fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1;
//   else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1; else 00. fwd_b likewise on ex_rs2.
//  Load-use (comb): lu = ex_mem_read && ex_rd!=0 && ((id_use_rs1&&ex_rd==id_rs1)||(id_use_rs2&&ex_rd==id_rs2)).
//  FSM states RUN, DRAIN, DONE; per-cycle priority in RUN:
//   1 ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count++; id_halt/lu ignored.
//   2 lu: pc_write=0, if_id_write=0, id_ex_bubble=1 (exactly 1 stall cycle); stall_count++.
//   3 id_halt: pc_write=0, if_id_write=0, id_ex_bubble=1; load drain counter=DRAIN_CYCLES-1; ->DRAIN.
//   4 else pc_write=1, if_id_write=1, flush/bubble=0.
//  DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1; branch/lu ignored; counter-- each cycle;
//   at counter==0 -> DONE next edge. DONE: same freeze outputs, end_program=1 (registered), sticky until reset.
//  cycle_count increments every cycle in RUN and DRAIN, not in DONE; all counters saturate, never wrap.
//  Latency: hazard/forward outputs combinational, same cycle as inputs; end_program rises DRAIN_CYCLES+1
//   edges after the edge where id_halt is accepted.
// STRUCTURE
//  Shared package pipe_ctrl_pkg: FWD_REG/FWD_EXMEM/FWD_MEMWB codes, state encodings, NOP word 32'h13.
//  One sub-module: hazard_fwd_unit (pure comb forwarding + lu detect); FSM and counters in this module.
// TESTING
//  addi x1,x0,10; addi x2,x1,5 -> fwd_a=10 in EX of 2nd; x2=15; no stall.
//  ld x5,0(x0); add x6,x5,x5 -> one cycle pc_write=0,id_ex_bubble=1; stall_count=1; fwd_a=fwd_b=01 next.
//  beq x0,x0,+8 taken with lu in same cycle -> flush only; flush_count=1, stall_count unchanged.
//  Reference program (7 instrs then 32'h0) -> end_program after DRAIN_CYCLES+1 edges; x7=-80;
//   cycle_count frozen thereafter.
//  reset low for 1 cycle during DRAIN -> state RUN, counters 0, end_program 0, refetch from PC 0.
//  Write to x0 in EX/MEM with ex_rs1=0 -> fwd_a=00.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned FWD_W   = 2;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned FLUSH_W = 16;

  localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_ADV    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};

  // Youngest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
  function automatic logic [FWD_W-1:0] fwd_select(
    input logic             mem_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_rd,
    input logic [REG_W-1:0] rs
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == rs)) return FWD_EXMEM;
    if (wb_we && (wb_rd != '0) && (wb_rd == rs))    return FWD_MEMWB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage register fields in, control out.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic [REG_W-1:0]   id_rs1;
  logic [REG_W-1:0]   id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic               id_halt;
  logic [REG_W-1:0]   ex_rs1;
  logic [REG_W-1:0]   ex_rs2;
  logic [REG_W-1:0]   ex_rd;
  logic               ex_mem_read;
  logic               ex_branch_taken;
  logic [REG_W-1:0]   mem_rd;
  logic               mem_reg_write;
  logic [REG_W-1:0]   wb_rd;
  logic               wb_reg_write;

  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic               id_ex_bubble;
  logic [FWD_W-1:0]   fwd_a;
  logic [FWD_W-1:0]   fwd_b;
  logic               end_program;
  logic [CNT_W-1:0]   cycle_count;
  logic [STALL_W-1:0] stall_count;
  logic [FLUSH_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
    output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    output mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
    input  end_program, cycle_count, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
    input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    input  mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
    output end_program, cycle_count, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Pure combinational EX operand forwarding select and load-use detection.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_ex_rs1,
  input  logic [REG_W-1:0] i_ex_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_reg_write,
  output logic [FWD_W-1:0] o_fwd_a_c,
  output logic [FWD_W-1:0] o_fwd_b_c,
  output logic             o_load_use_c
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  always_comb begin
    o_fwd_a_c = fwd_select(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_ex_rs1);
    o_fwd_b_c = fwd_select(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_ex_rs2);
  end

  // A load in EX whose result is consumed by the instruction in ID must wait one cycle.
  always_comb begin
    w_hit_rs1    = i_id_use_rs1 && (i_ex_rd == i_id_rs1);
    w_hit_rs2    = i_id_use_rs2 && (i_ex_rd == i_id_rs2);
    o_load_use_c = i_ex_mem_read && (i_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stalls, flushes, forwarding,
// end-of-program drain and execution-time counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
)(
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e             r_state;
  state_e             w_state_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_next;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [STALL_W-1:0] r_stall_count;
  logic [FLUSH_W-1:0] r_flush_count;
  logic               r_end_program;

  pipe_ctrl_t         w_ctrl;
  logic               w_stall_inc;
  logic               w_flush_inc;
  logic               w_load_use;
  logic [FWD_W-1:0]   w_fwd_a;
  logic [FWD_W-1:0]   w_fwd_b;

  hazard_fwd_unit u_hazard_fwd (
    .i_id_rs1        (bus.id_rs1),
    .i_id_rs2        (bus.id_rs2),
    .i_id_use_rs1    (bus.id_use_rs1),
    .i_id_use_rs2    (bus.id_use_rs2),
    .i_ex_rs1        (bus.ex_rs1),
    .i_ex_rs2        (bus.ex_rs2),
    .i_ex_rd         (bus.ex_rd),
    .i_ex_mem_read   (bus.ex_mem_read),
    .i_mem_rd        (bus.mem_rd),
    .i_mem_reg_write (bus.mem_reg_write),
    .i_wb_rd         (bus.wb_rd),
    .i_wb_reg_write  (bus.wb_reg_write),
    .o_fwd_a_c       (w_fwd_a),
    .o_fwd_b_c       (w_fwd_b),
    .o_load_use_c    (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  // Branch beats load-use beats halt; once draining, the front end stays frozen.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    w_ctrl       = CTRL_FREEZE;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    if (!reset) begin
      w_ctrl = CTRL_RESET;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            w_ctrl      = CTRL_FLUSH;
            w_flush_inc = 1'b1;
          end else if (w_load_use) begin
            w_ctrl      = CTRL_FREEZE;
            w_stall_inc = 1'b1;
          end else if (bus.id_halt) begin
            w_ctrl       = CTRL_FREEZE;
            w_drain_next = DRAIN_W'(DRAIN_CYCLES - 1);
            w_state_next = ST_DRAIN;
          end else begin
            w_ctrl = CTRL_ADV;
          end
        end
        ST_DRAIN: begin
          w_ctrl = CTRL_FREEZE;
          if (r_drain_cnt == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_drain_next = r_drain_cnt - DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          w_ctrl = CTRL_FREEZE;
        end
        default: begin
          w_ctrl       = CTRL_FREEZE;
          w_state_next = ST_RUN;
        end
      endcase
    end
  end

  // Saturating execution-time counters; end_program lags DONE by one edge and stays set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_end_program <= 1'b0;
    end else begin
      if ((r_state != ST_DONE) && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_stall_inc && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_W'(1);
      end
      if (w_flush_inc && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + FLUSH_W'(1);
      end
      r_end_program <= r_end_program | (r_state == ST_DONE);
    end
  end

  assign bus.pc_write     = w_ctrl.pc_write;
  assign bus.if_id_write  = w_ctrl.if_id_write;
  assign bus.if_id_flush  = w_ctrl.if_id_flush;
  assign bus.id_ex_bubble = w_ctrl.id_ex_bubble;
  assign bus.fwd_a        = reset ? w_fwd_a : FWD_REG;
  assign bus.fwd_b        = reset ? w_fwd_b : FWD_REG;
  assign bus.end_program  = r_end_program;
  assign bus.cycle_count  = r_cycle_count;
  assign bus.stall_count  = r_stall_count;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned DRAIN = 4;
  localparam int unsigned CW    = 32;

  logic clk;
  logic reset;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Model state: counters and edges elapsed since halt acceptance (-1 = not halted).
  int m_cycles;
  int m_stalls;
  int m_flushes;
  int m_since;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (!reset) return 2'b00;
    if (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == rs) return 2'b10;
    if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_lu();
    return bus.ex_mem_read && bus.ex_rd != 5'd0 &&
           ((bus.id_use_rs1 && bus.ex_rd == bus.id_rs1) || (bus.id_use_rs2 && bus.ex_rd == bus.id_rs2));
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  function automatic logic [3:0] ref_ctrl();
    if (!reset) return 4'b0011;
    if (m_since >= 0) return 4'b0001;
    if (bus.ex_branch_taken) return 4'b1111;
    if (ref_lu()) return 4'b0001;
    if (bus.id_halt) return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_cycles = 0; m_stalls = 0; m_flushes = 0; m_since = -1;
    end else begin
      if (m_since < int'(DRAIN)) m_cycles = m_cycles + 1;
      if (m_since >= 0) begin
        m_since = m_since + 1;
      end else if (bus.ex_branch_taken) begin
        if (m_flushes < 65535) m_flushes = m_flushes + 1;
      end else if (ref_lu()) begin
        if (m_stalls < 65535) m_stalls = m_stalls + 1;
      end else if (bus.id_halt) begin
        m_since = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
  endtask

  task automatic set_idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_halt = 0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_mem_read = 0; bus.ex_branch_taken = 0;
    bus.mem_rd = '0; bus.mem_reg_write = 0; bus.wb_rd = '0; bus.wb_reg_write = 0;
  endtask

  task automatic set_random(input int halt_pct, input int br_pct);
    bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
    bus.id_use_rs1 = 1'($urandom); bus.id_use_rs2 = 1'($urandom);
    bus.id_halt = ($urandom_range(0, 99) < halt_pct);
    bus.ex_rs1 = 5'($urandom_range(0, 3)); bus.ex_rs2 = 5'($urandom_range(0, 3));
    bus.ex_rd = 5'($urandom_range(0, 3)); bus.ex_mem_read = 1'($urandom);
    bus.ex_branch_taken = ($urandom_range(0, 99) < br_pct);
    bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_reg_write = 1'($urandom);
    bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_reg_write = 1'($urandom);
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    bus.mem_reg_write = 1; bus.mem_rd = 5'd3; bus.ex_rs1 = 5'd3; bus.ex_rs2 = 5'd3;
    @(negedge clk); #1;
    n_checks++;
    if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== 4'b0011) begin
      $display("FAIL reset_ctrl: got %b want 0011",
               {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble});
      n_errors++;
    end
    n_checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin
      $display("FAIL reset_fwd: got %b want 0000", {bus.fwd_a, bus.fwd_b}); n_errors++;
    end
    step();
    @(negedge clk); #1;
    n_checks++;
    if (bus.cycle_count !== 32'd0 || bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0 ||
        bus.end_program !== 1'b0) begin
      $display("FAIL reset_regs: got cyc=%0d stl=%0d fl=%0d end=%b want 0 0 0 0",
               bus.cycle_count, bus.stall_count, bus.flush_count, bus.end_program);
      n_errors++;
    end
    reset = 1'b1;
    set_idle();
    step();
  endtask

  task automatic test_forwarding();
    // {mem_we, mem_rd, wb_we, wb_rd, ex_rs1, ex_rs2, fwd_a, fwd_b}
    logic [29:0] cases [5];
    cases[0] = {1'b1, 5'd1, 1'b0, 5'd0, 5'd1, 5'd0, 2'b10, 2'b00};
    cases[1] = {1'b0, 5'd0, 1'b1, 5'd5, 5'd5, 5'd5, 2'b01, 2'b01};
    cases[2] = {1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd7, 2'b10, 2'b00};
    cases[3] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    cases[4] = {1'b0, 5'd4, 1'b1, 5'd4, 5'd9, 5'd4, 2'b00, 2'b01};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_idle();
      {bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd, bus.ex_rs1, bus.ex_rs2} = cases[i][29:4];
      #1;
      n_checks++;
      if ({bus.fwd_a, bus.fwd_b} !== cases[i][3:0]) begin
        $display("FAIL fwd_case%0d: got %b want %b", i, {bus.fwd_a, bus.fwd_b}, cases[i][3:0]);
        n_errors++;
      end
      n_checks++;
      if (bus.pc_write !== 1'b1 || bus.id_ex_bubble !== 1'b0) begin
        $display("FAIL fwd_no_stall%0d: got pc_write=%b bubble=%b want 1 0", i, bus.pc_write, bus.id_ex_bubble);
        n_errors++;
      end
      step();
    end
  endtask

  task automatic test_load_use();
    int base;
    base = m_stalls;
    // ld x5 in EX, add x6,x5,x5 in ID
    @(negedge clk);
    set_idle();
    bus.ex_mem_read = 1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs1 = 1; bus.id_use_rs2 = 1;
    #1;
    n_checks++;
    if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== 4'b0001) begin
      $display("FAIL lu_stall: got %b want 0001",
               {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble});
      n_errors++;
    end
    step();
    // load in MEM, bubble in EX: add may advance
    @(negedge clk);
    set_idle();
    bus.mem_rd = 5'd5; bus.mem_reg_write = 1;
    bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs1 = 1; bus.id_use_rs2 = 1;
    #1;
    n_checks++;
    if (bus.pc_write !== 1'b1 || bus.stall_count !== 16'(base + 1)) begin
      $display("FAIL lu_release: got pc_write=%b stall=%0d want 1 %0d", bus.pc_write, bus.stall_count, base + 1);
      n_errors++;
    end
    step();
    // add in EX, load in WB
    @(negedge clk);
    set_idle();
    bus.ex_rs1 = 5'd5; bus.ex_rs2 = 5'd5; bus.wb_rd = 5'd5; bus.wb_reg_write = 1;
    #1;
    n_checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0101) begin
      $display("FAIL lu_fwd_wb: got %b want 0101", {bus.fwd_a, bus.fwd_b}); n_errors++;
    end
    step();
    // load to x0, and load with operand unused: neither stalls
    @(negedge clk);
    set_idle();
    bus.ex_mem_read = 1; bus.ex_rd = 5'd0; bus.id_use_rs1 = 1;
    #1;
    n_checks++;
    if (bus.pc_write !== 1'b1) begin
      $display("FAIL lu_x0: got pc_write=%b want 1", bus.pc_write); n_errors++;
    end
    step();
    @(negedge clk);
    bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs1 = 1; bus.id_use_rs2 = 0;
    #1;
    n_checks++;
    if (bus.pc_write !== 1'b1) begin
      $display("FAIL lu_unused: got pc_write=%b want 1", bus.pc_write); n_errors++;
    end
    step();
  endtask

  task automatic test_branch_priority();
    int s0, f0;
    s0 = m_stalls; f0 = m_flushes;
    @(negedge clk);
    set_idle();
    bus.ex_branch_taken = 1; bus.ex_mem_read = 1; bus.ex_rd = 5'd2;
    bus.id_rs1 = 5'd2; bus.id_use_rs1 = 1; bus.id_halt = 1;
    #1;
    n_checks++;
    if ({bus.pc_write, bus.if_id_flush, bus.id_ex_bubble} !== 3'b111) begin
      $display("FAIL br_ctrl: got %b want 111", {bus.pc_write, bus.if_id_flush, bus.id_ex_bubble});
      n_errors++;
    end
    step();
    @(negedge clk);
    set_idle();
    #1;
    n_checks++;
    if (bus.flush_count !== 16'(f0 + 1) || bus.stall_count !== 16'(s0) || bus.pc_write !== 1'b1) begin
      $display("FAIL br_counts: got fl=%0d stl=%0d pc_write=%b want %0d %0d 1",
               bus.flush_count, bus.stall_count, bus.pc_write, f0 + 1, s0);
      n_errors++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = m_flushes;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      bus.ex_branch_taken = 1;
      step();
    end
    @(negedge clk);
    set_idle();
    #1;
    n_checks++;
    if (bus.flush_count !== 16'(f0 + 3)) begin
      $display("FAIL b2b_flush: got %0d want %0d", bus.flush_count, f0 + 3); n_errors++;
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      set_random(0, 15);
      #1;
      n_checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== ref_ctrl() ||
          bus.fwd_a !== ref_fwd(bus.ex_rs1) || bus.fwd_b !== ref_fwd(bus.ex_rs2)) begin
        $display("FAIL rnd_comb[%0d]: got ctrl=%b fa=%b fb=%b want ctrl=%b fa=%b fb=%b", i,
                 {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble}, bus.fwd_a, bus.fwd_b,
                 ref_ctrl(), ref_fwd(bus.ex_rs1), ref_fwd(bus.ex_rs2));
        n_errors++;
      end
      n_checks++;
      if (bus.cycle_count !== 32'(m_cycles) || bus.stall_count !== 16'(m_stalls) ||
          bus.flush_count !== 16'(m_flushes) || bus.end_program !== 1'b0) begin
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d end=%b want %0d/%0d/%0d end=0", i,
                 bus.cycle_count, bus.stall_count, bus.flush_count, bus.end_program,
                 m_cycles, m_stalls, m_flushes);
        n_errors++;
      end
      step();
    end
  endtask

  task automatic test_halt_drain();
    int rise;
    rise = -1;
    @(negedge clk);
    set_idle();
    bus.id_halt = 1;
    #1;
    n_checks++;
    if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== 4'b0001) begin
      $display("FAIL halt_accept: got %b want 0001",
               {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble});
      n_errors++;
    end
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_random(50, 50);
      #1;
      if (bus.end_program === 1'b1 && rise < 0) rise = m_since;
      n_checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== 4'b0001 ||
          bus.end_program !== (m_since >= int'(DRAIN) + 1) || bus.cycle_count !== 32'(m_cycles) ||
          bus.flush_count !== 16'(m_flushes) || bus.stall_count !== 16'(m_stalls)) begin
        $display("FAIL drain[%0d]: got ctrl=%b end=%b cyc=%0d fl=%0d stl=%0d want ctrl=0001 end=%b cyc=%0d fl=%0d stl=%0d",
                 m_since, {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble},
                 bus.end_program, bus.cycle_count, bus.flush_count, bus.stall_count,
                 (m_since >= int'(DRAIN) + 1), m_cycles, m_flushes, m_stalls);
        n_errors++;
      end
      step();
    end
    n_checks++;
    if (rise != int'(DRAIN) + 1) begin
      $display("FAIL end_latency: got %0d edges want %0d", rise, DRAIN + 1); n_errors++;
    end
  endtask

  task automatic test_reset_during_drain();
    @(negedge clk);
    set_idle();
    reset = 1'b0;
    step();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    bus.id_halt = 1;
    step();
    @(negedge clk);
    set_idle();
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== 4'b0011) begin
      $display("FAIL rstdrain_ctrl: got %b want 0011",
               {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble});
      n_errors++;
    end
    step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.cycle_count !== 32'd0 || bus.end_program !== 1'b0 || bus.pc_write !== 1'b1 ||
        bus.if_id_write !== 1'b1) begin
      $display("FAIL rstdrain_run: got cyc=%0d end=%b pc_write=%b if_id_write=%b want 0 0 1 1",
               bus.cycle_count, bus.end_program, bus.pc_write, bus.if_id_write);
      n_errors++;
    end
    step();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_random(0, 20);
      #1;
      n_checks++;
      if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble} !== ref_ctrl() ||
          bus.cycle_count !== 32'(m_cycles) || bus.stall_count !== 16'(m_stalls) ||
          bus.flush_count !== 16'(m_flushes)) begin
        $display("FAIL rstdrain_rnd[%0d]: got ctrl=%b cyc=%0d stl=%0d fl=%0d want ctrl=%b cyc=%0d stl=%0d fl=%0d", i,
                 {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble},
                 bus.cycle_count, bus.stall_count, bus.flush_count,
                 ref_ctrl(), m_cycles, m_stalls, m_flushes);
        n_errors++;
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_cycles = 0; m_stalls = 0; m_flushes = 0; m_since = -1;
    reset = 1'b0;
    set_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_back_to_back();
    test_random();
    test_halt_drain();
    test_reset_during_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
